// File: rtl/axi_ic_aw_arbiter_pkg.sv
// rtl/axi_ic_aw_arbiter_pkg.sv - shared types and width helper for the AW arbiter
//
// Contents:
//   aw_arb_state_e : per-slave arbiter state (IDLE / ADDR / DATA)
//   clog2_min1     : $clog2 that never returns less than 1, for index widths
package axi_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no owner
    ADDR = 2'd1,  // granted, AW not yet accepted
    DATA = 2'd2   // AW accepted, W burst still pending
  } aw_arb_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_ic_aw_arbiter_if.sv
// rtl/axi_ic_aw_arbiter_if.sv - AW routing / W release bundle around the arbiter
//
// Signals (suffix is direction as seen by the arbiter):
//   aw_valid_i  [NumMasters]          master AWVALID
//   aw_slave_i  [NumMasters] SelWidth decoded target slave of each master's AW
//   aw_ready_o  [NumMasters]          AWREADY back to each master
//   aw_valid_o  [NumSlaves]           AWVALID to each slave
//   aw_ready_i  [NumSlaves]           slave AWREADY
//   wlast_i     [NumSlaves]           W router: wlast & wvalid of the granted master
//   w_ready_i   [NumSlaves]           W router: skid-buffer ready
//   wr_grant_o  [NumSlaves] GrantWidth granted master index per slave
//   slave_sel_o [NumMasters] SelWidth latched target slave per master
// Modports: master = the arbiter, slave = the surrounding fabric.
interface axi_ic_aw_arbiter_if import axi_ic_pkg::*; #(
  parameter int NumMasters = 2,
  parameter int NumSlaves  = 2
) ();

  localparam int GrantWidth = clog2_min1(NumMasters);
  localparam int SelWidth   = clog2_min1(NumSlaves);

  logic [NumMasters-1:0] aw_valid_i;
  logic [SelWidth-1:0]   aw_slave_i [NumMasters];
  logic [NumMasters-1:0] aw_ready_o;
  logic [NumSlaves-1:0]  aw_valid_o;
  logic [NumSlaves-1:0]  aw_ready_i;
  logic [NumSlaves-1:0]  wlast_i;
  logic [NumSlaves-1:0]  w_ready_i;
  logic [GrantWidth-1:0] wr_grant_o [NumSlaves];
  logic [SelWidth-1:0]   slave_sel_o [NumMasters];

  modport master (
    input  aw_valid_i, aw_slave_i, aw_ready_i, wlast_i, w_ready_i,
    output aw_ready_o, aw_valid_o, wr_grant_o, slave_sel_o
  );

  modport slave (
    output aw_valid_i, aw_slave_i, aw_ready_i, wlast_i, w_ready_i,
    input  aw_ready_o, aw_valid_o, wr_grant_o, slave_sel_o
  );

endinterface

// File: rtl/axi_ic_aw_arbiter_rr_arbiter.sv
// rtl/axi_ic_aw_arbiter_rr_arbiter.sv - per-slave request picker (round-robin or fixed priority)
//
// Ports:
//   aclk, rst_n   clock, asynchronous active-low reset
//   req_i         request vector, one bit per master
//   grant_en_i    strobe: the owning slave takes a new owner this cycle
//   gnt_onehot_o  one-hot winner (combinational)
//   gnt_idx_o     winner index (combinational)
// Build option: AXI_IC_AW_RR_EN selects round-robin with a pointer that moves
// to winner+1 on every grant_en_i; without it the lowest index wins and there
// is no state.
module axi_ic_rr_arbiter import axi_ic_pkg::*; #(
  parameter int NumMasters = 2,
  localparam int GrantWidth = clog2_min1(NumMasters)
) (
  input  logic                  aclk,
  input  logic                  rst_n,
  input  logic [NumMasters-1:0] req_i,
  input  logic                  grant_en_i,
  output logic [NumMasters-1:0] gnt_onehot_o,
  output logic [GrantWidth-1:0] gnt_idx_o
);

  logic found;

`ifdef AXI_IC_AW_RR_EN
  logic [GrantWidth-1:0] ptr_q;
  logic [GrantWidth-1:0] idx;

  // Search starts at the pointer and wraps, so the master after the last
  // winner gets first chance.
  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    found        = 1'b0;
    idx          = '0;
    for (int i = 0; i < NumMasters; i++) begin
      idx = GrantWidth'((int'(ptr_q) + i) % NumMasters);
      if (!found && req_i[idx]) begin
        found             = 1'b1;
        gnt_onehot_o[idx] = 1'b1;
        gnt_idx_o         = idx;
      end
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (grant_en_i) begin
      ptr_q <= (int'(gnt_idx_o) == NumMasters - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end
`else
  logic unused_sig;

  assign unused_sig = aclk ^ rst_n ^ grant_en_i;

  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    found        = 1'b0;
    for (int i = 0; i < NumMasters; i++) begin
      if (!found && req_i[i]) begin
        found           = 1'b1;
        gnt_onehot_o[i] = 1'b1;
        gnt_idx_o       = GrantWidth'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/axi_ic_aw_arbiter.sv
// rtl/axi_ic_aw_arbiter.sv - per-slave AW arbiter holding the grant until the W burst ends
//
// Ports:
//   aclk   clock
//   rst_n  asynchronous active-low reset
//   bus    axi_ic_aw_arbiter_if.master (AW valid/ready routing, W release
//          inputs, wr_grant_o / slave_sel_o towards the W router)
// Build option: AXI_IC_AW_RR_EN turns each slave's picker into round-robin;
// default is fixed priority, lowest master index first.
module axi_ic_aw_arbiter import axi_ic_pkg::*; #(
  parameter int NumMasters = 2,
  parameter int NumSlaves  = 2
) (
  input logic                  aclk,
  input logic                  rst_n,
  axi_ic_aw_arbiter_if.master  bus
);

  localparam int GrantWidth = clog2_min1(NumMasters);
  localparam int SelWidth   = clog2_min1(NumSlaves);

  aw_arb_state_e         state_q [NumSlaves];
  aw_arb_state_e         state_d [NumSlaves];
  logic [NumSlaves-1:0]  w_done_q, w_done_d;
  logic [GrantWidth-1:0] grant_q [NumSlaves];
  logic [GrantWidth-1:0] grant_d [NumSlaves];
  logic [SelWidth-1:0]   sel_q [NumMasters];

  logic [NumMasters-1:0] busy;
  logic [NumMasters-1:0] req [NumSlaves];
  logic [NumMasters-1:0] gnt_oh [NumSlaves];
  logic [GrantWidth-1:0] gnt_idx [NumSlaves];
  logic [NumSlaves-1:0]  grant_en;
  logic [NumSlaves-1:0]  aw_valid;
  logic [NumMasters-1:0] aw_ready;
  logic [NumSlaves-1:0]  aw_hs;
  logic [NumSlaves-1:0]  wl_hs;

  // A master that owns any slave is out of the running everywhere: this is
  // what limits each master to one outstanding write.
  always_comb begin
    busy = '0;
    for (int s = 0; s < NumSlaves; s++) begin
      if (state_q[s] != IDLE) busy[grant_q[s]] = 1'b1;
    end
  end

  always_comb begin
    for (int s = 0; s < NumSlaves; s++) begin
      req[s] = '0;
      for (int m = 0; m < NumMasters; m++) begin
        req[s][m] = bus.aw_valid_i[m] && (bus.aw_slave_i[m] == SelWidth'(s)) && !busy[m];
      end
      grant_en[s] = (state_q[s] == IDLE) && (|req[s]);
    end
  end

  for (genvar s = 0; s < NumSlaves; s++) begin : g_arb
    axi_ic_rr_arbiter #(.NumMasters(NumMasters)) u_arb (
      .aclk         (aclk),
      .rst_n        (rst_n),
      .req_i        (req[s]),
      .grant_en_i   (grant_en[s]),
      .gnt_onehot_o (gnt_oh[s]),
      .gnt_idx_o    (gnt_idx[s])
    );
  end

  // AW routing is purely combinational while a slave sits in ADDR.
  always_comb begin
    aw_valid = '0;
    aw_ready = '0;
    for (int s = 0; s < NumSlaves; s++) begin
      if (state_q[s] == ADDR) begin
        aw_valid[s] = bus.aw_valid_i[grant_q[s]];
        if (bus.aw_ready_i[s]) aw_ready[grant_q[s]] = 1'b1;
      end
    end
  end

  assign aw_hs = aw_valid & bus.aw_ready_i;
  assign wl_hs = bus.wlast_i & bus.w_ready_i;

  // W may finish before AW is accepted; w_done remembers that so the AW
  // handshake can release the slave straight from ADDR.
  always_comb begin
    for (int s = 0; s < NumSlaves; s++) begin
      state_d[s]  = state_q[s];
      w_done_d[s] = w_done_q[s];
      grant_d[s]  = grant_q[s];
      case (state_q[s])
        IDLE: begin
          if (grant_en[s]) begin
            state_d[s] = ADDR;
            grant_d[s] = gnt_idx[s];
          end
        end
        ADDR: begin
          if (aw_hs[s]) begin
            state_d[s]  = (w_done_q[s] || wl_hs[s]) ? IDLE : DATA;
            w_done_d[s] = 1'b0;
          end else if (wl_hs[s]) begin
            w_done_d[s] = 1'b1;
          end
        end
        DATA: begin
          if (wl_hs[s]) state_d[s] = IDLE;
        end
        default: begin
          state_d[s]  = IDLE;
          w_done_d[s] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NumSlaves; s++) begin
        state_q[s] <= IDLE;
        grant_q[s] <= '0;
      end
      w_done_q <= '0;
    end else begin
      for (int s = 0; s < NumSlaves; s++) begin
        state_q[s] <= state_d[s];
        grant_q[s] <= grant_d[s];
      end
      w_done_q <= w_done_d;
    end
  end

  // Each master targets a single slave, so at most one slave can hand it a
  // grant in any cycle.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < NumMasters; m++) sel_q[m] <= '0;
    end else begin
      for (int s = 0; s < NumSlaves; s++) begin
        for (int m = 0; m < NumMasters; m++) begin
          if (grant_en[s] && gnt_oh[s][m]) sel_q[m] <= SelWidth'(s);
        end
      end
    end
  end

  assign bus.aw_valid_o  = aw_valid;
  assign bus.aw_ready_o  = aw_ready;
  assign bus.wr_grant_o  = grant_q;
  assign bus.slave_sel_o = sel_q;

endmodule

// File: tb/tb_axi_ic_aw_arbiter.sv
// tb/tb_axi_ic_aw_arbiter.sv - self-checking bench for axi_ic_aw_arbiter
module tb_axi_ic_aw_arbiter;

`ifdef AXI_IC_AW_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  // sl = {aw_slave_i[1], aw_slave_i[0]}, eg = {grant1, grant0}, es = {sel1, sel0}
  typedef struct {
    string      name;
    logic [1:0] av, sl, ar, wl, wr;
    logic [1:0] eavo, earo, eg, es;
  } vec_t;

  logic aclk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  vec_t tbl[$];
  vec_t exp_q[$];

  axi_ic_aw_arbiter_if #(.NumMasters(2), .NumSlaves(2)) bus ();

  axi_ic_aw_arbiter #(.NumMasters(2), .NumSlaves(2)) dut (
    .aclk  (aclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  function automatic vec_t mk(input string n, input logic [1:0] av, sl, ar, wl, wr,
                              input logic [1:0] eavo, earo, eg, es);
    vec_t v;
    v.name = n; v.av = av; v.sl = sl; v.ar = ar; v.wl = wl; v.wr = wr;
    v.eavo = eavo; v.earo = earo; v.eg = eg; v.es = es;
    return v;
  endfunction

  function automatic logic [7:0] actual();
    return {bus.aw_valid_o, bus.aw_ready_o, bus.wr_grant_o[1], bus.wr_grant_o[0],
            bus.slave_sel_o[1], bus.slave_sel_o[0]};
  endfunction

  task automatic check(input string n, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got avo=%b aro=%b grant=%b sel=%b, expected avo=%b aro=%b grant=%b sel=%b",
               n, got[7:6], got[5:4], got[3:2], got[1:0], exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
    end
  endtask

  // Called at posedge+1: drive, queue the expectation, compare at negedge.
  task automatic run_vec(input vec_t v);
    vec_t e;
    bus.aw_valid_i    = v.av;
    bus.aw_slave_i[0] = v.sl[0];
    bus.aw_slave_i[1] = v.sl[1];
    bus.aw_ready_i    = v.ar;
    bus.wlast_i       = v.wl;
    bus.w_ready_i     = v.wr;
    exp_q.push_back(v);
    @(negedge aclk);
    e = exp_q.pop_front();
    check(e.name, actual(), {e.eavo, e.earo, e.eg, e.es});
    @(posedge aclk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus.aw_valid_i = '0; bus.aw_slave_i[0] = '0; bus.aw_slave_i[1] = '0;
    bus.aw_ready_i = '0; bus.wlast_i = '0; bus.w_ready_i = '0;

    //        name         av     sl     ar     wl     wr     avo    aro    grant  sel
    tbl.push_back(mk("single_req",   2'b01, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    tbl.push_back(mk("single_addr",  2'b01, 2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01));
    tbl.push_back(mk("single_beat1", 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk("single_beat2", 2'b00, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk("wlast_noready",2'b00, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk("single_beat4", 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk("idle_regrant", 2'b10, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01));
    tbl.push_back(mk("aw_wl_same",   2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11));
    tbl.push_back(mk("after_same",   2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11));
    tbl.push_back(mk("w_before_aw",  2'b01, 2'b11, 2'b00, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11));
    tbl.push_back(mk("aw_after_w",   2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11));
    tbl.push_back(mk("skip_data",    2'b10, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11));
    tbl.push_back(mk("addr_m1",      2'b10, 2'b11, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b10, 2'b11));
    tbl.push_back(mk("valid_drop",   2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11));
    tbl.push_back(mk("held_addr",    2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11));
    tbl.push_back(mk("idle_hold",    2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11));
    tbl.push_back(mk("cont_idle1",   2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11));
    tbl.push_back(mk("cont_gnt1",    2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10));
    tbl.push_back(mk("cont_idle2",   2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10));
    tbl.push_back(mk("cont_gnt2",    2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b01,
                     Rr ? 2'b10 : 2'b01, Rr ? 2'b11 : 2'b10, Rr ? 2'b00 : 2'b10));
    tbl.push_back(mk("cont_idle3",   2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00,
                     Rr ? 2'b11 : 2'b10, Rr ? 2'b00 : 2'b10));
    tbl.push_back(mk("cont_gnt3",    2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 2'b10,
                     Rr ? 2'b00 : 2'b10));
    tbl.push_back(mk("cont_idle4",   2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10,
                     Rr ? 2'b00 : 2'b10));
    tbl.push_back(mk("cont_gnt4",    2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b01,
                     Rr ? 2'b10 : 2'b01, Rr ? 2'b11 : 2'b10, Rr ? 2'b00 : 2'b10));

    @(posedge aclk);
    #1;
    run_vec(mk("reset_state_a", 2'b11, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    run_vec(mk("reset_state_b", 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Parallel grants, then M0 retargets S1 and must wait for both bursts.
    run_vec(mk("par_req",      2'b11, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00,
               Rr ? 2'b11 : 2'b10, Rr ? 2'b00 : 2'b10));
    run_vec(mk("par_grant",    2'b11, 2'b10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b10, 2'b10));
    run_vec(mk("par_aw_hs",    2'b11, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10));
    run_vec(mk("par_blk_both", 2'b01, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10));
    run_vec(mk("par_s0_last",  2'b01, 2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10));
    run_vec(mk("par_blk_s1",   2'b01, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10));
    run_vec(mk("par_s1_last",  2'b01, 2'b11, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10));
    run_vec(mk("par_s1_idle",  2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b10));
    run_vec(mk("par_m0_s1",    2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b11));
    run_vec(mk("rst_pre_hs",   2'b01, 2'b11, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11));
    run_vec(mk("rst_in_data",  2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11));

    // Asynchronous reset in the middle of a cycle while S1 is in DATA.
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", actual(), 8'h00);
    #3 rst_n = 1'b1;
    #1 check("post_reset_idle", actual(), 8'h00);
    @(posedge aclk);
    #1;
    run_vec(mk("post_reset_grant", 2'b01, 2'b11, 2'b00, 2'b00, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
